// File: rtl/uart_loopback_if.sv
// Serial pins of the UART echo endpoint.
// The board side drives uart_rx (master); the loopback drives uart_tx (slave).
interface uart_loopback_if;
  logic uart_rx;
  logic uart_tx;

  modport master (output uart_rx, input uart_tx);
  modport slave  (input uart_rx, output uart_tx);
endinterface

// File: rtl/uart_loopback.sv
// UART echo endpoint: 8E1 frames received on uart_rx are retransmitted on uart_tx.
// Define PARITY_CHECK_EN to drop frames whose parity bit mismatches.
module uart_loopback #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk50,
  input  logic reset,
  uart_loopback_if.slave uart
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // Probe points kept under fixed names
  logic       rx_ready;
  logic       tx_busy;
  logic [7:0] rx_byte;

  // ---------------- receive path ----------------
  logic            rx_s1_q, rx_s2_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_par_q, rx_par_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_ready_q, rx_ready_d;
  logic            rx_par_ok;

  assign rx_par_ok = !PAR_CHK || (rx_par_q == ^rx_shift_q);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart.uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_byte_d  = rx_byte_q;
    rx_ready_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start, and sets the mid-bit phase
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_state_d = RX_WAIT_HI;
          end else begin
            rx_state_d = RX_IDLE;
            if (rx_par_ok) begin
              rx_byte_d  = rx_shift_q;
              rx_ready_d = 1'b1;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HI: begin
        // Framing error: a low stop would otherwise look like a new start bit
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_par_q   <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_byte_q  <= rx_byte_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign rx_byte  = rx_byte_q;

  // ---------------- transmit path ----------------
  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_par_q, tx_par_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            tx_free, load_pend, load_rx;
  logic [7:0]      load_byte;

  // TX can take a new byte when idle or on the last cycle of a stop bit
  assign tx_free   = !tx_busy || (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST);
  assign load_pend = tx_free && pend_vld_q;
  assign load_rx   = tx_free && !pend_vld_q && rx_ready;
  assign load_byte = pend_vld_q ? pend_q : rx_byte;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (tx_state_q)
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_busy_d  = 1'b0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (load_pend || load_rx) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shift_d = load_byte;
      tx_par_d   = ^load_byte;
      tx_d       = 1'b0;
      tx_busy_d  = 1'b1;
    end

    // Buffer a byte TX cannot take now; a full buffer drops the newcomer
    if (load_pend) pend_vld_d = 1'b0;
    if (rx_ready && !load_rx && (!pend_vld_q || load_pend)) begin
      pend_d     = rx_byte;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign tx_busy      = tx_busy_q;
  assign uart.uart_tx = tx_q;

endmodule

// File: tb/tb_uart_loopback.sv
// Bench for uart_loopback: frame table plus hand sequences for glitch, pending buffer and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_loopback;
  localparam int CPB = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_ACC = 1'b0;
`else
  localparam bit PAR_ACC = 1'b1;
`endif

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  uart_loopback_if u_if();

  always #10 clk50 = ~clk50;

  uart_loopback #(.CLKS_PER_BIT(CPB)) dut (
    .clk50 (clk50),
    .reset (reset),
    .uart  (u_if)
  );

  int n_chk = 0, n_fail = 0;
  int rx_cnt = 0, tx_cnt = 0, rst_cnt = 0;
  int busy_run = 0, last_busy = 0;
  int exp_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    u_if.uart_rx = b;
    repeat (n) @(negedge clk50);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int stop_len);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    send_bit(par, CPB);
    send_bit(stp, stop_len);
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_rx.push_back(d);
    exp_tx.push_back(d);
    exp_cnt++;
    last_acc = d;
  endtask

  task automatic wait_quiet();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk50);
      if (exp_tx.size() == 0 && dut.tx_busy === 1'b0) done = 1'b1;
    end
    if (!done) chk("quiet_timeout", exp_tx.size(), 0);
    repeat (10) @(negedge clk50);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rx_cnt"}, rx_cnt, exp_cnt);
    chk({nm, "_tx_cnt"}, tx_cnt, exp_cnt);
    chk({nm, "_rx_byte"}, dut.rx_byte, last_acc);
    chk({nm, "_tx_idle"}, u_if.uart_tx, 1);
  endtask

  initial forever begin
    @(posedge reset);
    rst_cnt++;
  end

  initial forever begin
    @(negedge clk50);
    if (dut.tx_busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  // RX side: byte value, one-cycle pulse, start latency when TX was idle
  logic rx_busy0;
  initial forever begin
    @(negedge clk50);
    if (dut.rx_ready === 1'b1) begin
      rx_busy0 = dut.tx_busy;
      rx_cnt++;
      chk("rx_expected", exp_rx.size() > 0, 1);
      if (exp_rx.size() > 0) chk("rx_byte", dut.rx_byte, exp_rx.pop_front());
      @(negedge clk50);
      chk("rx_ready_width", dut.rx_ready, 0);
      if (!rx_busy0) chk("tx_start_latency", {u_if.uart_tx, dut.tx_busy}, 2'b01);
    end
  end

  // TX side: decode frames at mid-bit and compare against the scoreboard
  logic [9:0] mon_bits;
  logic       mon_start;
  logic [7:0] mon_e;
  int         mon_r0;
  initial forever begin
    @(negedge clk50);
    if (!reset && u_if.uart_tx === 1'b0) begin
      mon_r0 = rst_cnt;
      repeat (CPB / 2) @(negedge clk50);
      mon_start = u_if.uart_tx;
      for (int i = 0; i < 10; i++) begin
        repeat (CPB) @(negedge clk50);
        mon_bits[i] = u_if.uart_tx;
      end
      if (mon_r0 == rst_cnt) begin
        tx_cnt++;
        chk("tx_frame_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) begin
          mon_e = exp_tx.pop_front();
          chk("tx_start_bit", mon_start, 0);
          chk("tx_data", mon_bits[7:0], mon_e);
          chk("tx_parity", mon_bits[8], ^mon_e);
          chk("tx_stop", mon_bits[9], 1);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         gap;
    bit         accept;
    bit         chk_busy;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{"b55",     8'h55, 1'b0, 1'b1, 20, 1'b1,    1'b1};
    vecs[1] = '{"bAA",     8'hAA, 1'b0, 1'b1, 20, 1'b1,    1'b1};
    vecs[2] = '{"b00",     8'h00, 1'b0, 1'b1,  0, 1'b1,    1'b0};
    vecs[3] = '{"bFF",     8'hFF, 1'b0, 1'b1, 20, 1'b1,    1'b0};
    vecs[4] = '{"badpar55",8'h55, 1'b1, 1'b1, 20, PAR_ACC, 1'b0};
    vecs[5] = '{"frame12", 8'h12, 1'b0, 1'b0, 20, 1'b0,    1'b0};
    vecs[6] = '{"bA5",     8'hA5, 1'b0, 1'b1, 20, 1'b1,    1'b1};
    vecs[7] = '{"b01",     8'h01, 1'b1, 1'b1, 20, 1'b1,    1'b1};
    vecs[8] = '{"badpar80",8'h80, 1'b0, 1'b1, 20, PAR_ACC, 1'b0};

    u_if.uart_rx = 1'b1;
    repeat (3) @(negedge clk50);
    chk("rst_uart_tx", u_if.uart_tx, 1);
    chk("rst_rx_ready", dut.rx_ready, 0);
    chk("rst_tx_busy", dut.tx_busy, 0);
    chk("rst_rx_byte", dut.rx_byte, 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk50);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].accept) push_exp(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, CPB);
      if (vecs[i].gap > 0) begin
        send_bit(1'b1, vecs[i].gap);
        wait_quiet();
        chk_idle(vecs[i].nm);
        if (vecs[i].chk_busy) chk({vecs[i].nm, "_busy_len"}, last_busy, 11 * CPB);
      end
    end

    // Two-cycle low glitch must be rejected as a false start
    send_bit(1'b0, 2);
    send_bit(1'b1, 200);
    chk_idle("glitch");

    // Short stop bits let RX outpace TX so bytes queue in the pending buffer
    push_exp(8'h3A);
    push_exp(8'hC5);
    push_exp(8'h7E);
    send_frame(8'h3A, 1'b0, 1'b1, 5);
    send_frame(8'hC5, 1'b0, 1'b1, 5);
    send_frame(8'h7E, 1'b0, 1'b1, 5);
    send_bit(1'b1, 20);
    wait_quiet();
    chk_idle("pending");

    // Reset in the middle of echoing 0xAA
    push_exp(8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, CPB);
    send_bit(1'b1, 30);
    chk("pre_rst_busy", dut.tx_busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_uart_tx", u_if.uart_tx, 1);
    chk("mid_rst_tx_busy", dut.tx_busy, 0);
    chk("mid_rst_rx_byte", dut.rx_byte, 8'h00);
    exp_tx.delete();
    exp_rx.delete();
    exp_cnt  = 0;
    rx_cnt   = 0;
    tx_cnt   = 0;
    last_acc = 8'h00;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    send_bit(1'b1, 120);
    push_exp(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, CPB);
    send_bit(1'b1, 20);
    wait_quiet();
    chk_idle("post_rst");
    chk("post_rst_busy_len", last_busy, 11 * CPB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
